// File: rtl/spike_buffer_reader.sv
// Read-side controller for the 16-entry spike packet buffer: mirrors writer traffic for
// occupancy, fetches entries in write order and presents them on a registered valid/ready stage.
module spike_buffer_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wen,
  output logic [AW-1:0]         rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  overflow_q, overflow_d;

  logic has_data;
  logic is_full;
  logic pop;
  logic push;

  assign has_data = (count_q != '0);
  assign is_full  = (count_q == CW'(DEPTH));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    out_data_d = out_data_q;
    overflow_d = overflow_q;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (has_data) begin
          pop     = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (has_data) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A write at full with no pop has already clobbered the oldest unfetched entry.
    push = wen && !(is_full && !pop);
    if (wen && is_full && !pop) begin
      overflow_d = 1'b1;
    end

    if (pop) begin
      out_data_d = rd_data;
      rd_ptr_d   = rd_ptr_q + AW'(1);
    end

    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      out_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      out_data_q <= out_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign rd_addr   = rd_ptr_q;
  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = is_full;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_spike_buffer_reader.sv
// Testbench for spike_buffer_reader: models the 16-entry buffer and its writer, and checks
// the reader against a queue-based model of packets written, fetched and delivered.
module tb_spike_buffer_reader;

  logic        clk;
  logic        reset_n;
  logic        wen;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;

  // Buffer and its write counter (resets to 15 so the first write lands in entry 0)
  logic [31:0] mem [16];
  logic [3:0]  wr_addr;
  logic [31:0] wdata;

  // Model: packets written but not fetched, the output register, and error state
  logic [31:0] pending [$];
  logic        m_valid;
  logic [31:0] m_data;
  int          m_fetches;
  logic        m_overflow;
  logic        m_corrupt;

  logic [31:0] delivered [$];

  int n_checks;
  int n_fail;

  spike_buffer_reader #(
    .DATA_WIDTH(32),
    .DEPTH(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .wen(wen),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .count(count),
    .empty(empty),
    .full(full),
    .overflow(overflow)
  );

  assign rd_data = mem[rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    pending.delete();
    m_valid    = 1'b0;
    m_data     = 32'h0;
    m_fetches  = 0;
    m_overflow = 1'b0;
    m_corrupt  = 1'b0;
    wr_addr    = 4'hF;
  endtask

  // One clock of the model, using the inputs held across the rising edge
  task automatic modelStep();
    bit pop;
    bit drop;
    pop  = (pending.size() > 0) && (!m_valid || out_ready);
    drop = wen && (pending.size() == 16) && !pop;
    if (pop) begin
      // At full, the same-cycle write lands in the very entry being fetched
      if (wen && pending.size() == 16) m_corrupt = 1'b1;
      m_data  = pending.pop_front();
      m_valid = 1'b1;
      m_fetches++;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if (drop) begin
      m_overflow = 1'b1;
      m_corrupt  = 1'b1;
    end else if (wen) begin
      pending.push_back(wdata);
    end
    if (wen) wr_addr = wr_addr + 4'd1;
  endtask

  // Called at a falling edge; returns at the next falling edge
  task automatic applyStimulus(input logic w, input logic r, input logic [31:0] d);
    wen       = w;
    out_ready = r;
    wdata     = d;
    if (w) mem[wr_addr + 4'd1] = d;
    if (out_valid && r) delivered.push_back(out_data);
    @(posedge clk);
    #1 modelStep();
    @(negedge clk);
  endtask

  task automatic doReset();
    #2 reset_n = 1'b0;
    wen       = 1'b0;
    out_ready = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
      checkOutput("count", 32'(count), 32'(pending.size()));
      checkOutput("empty", 32'(empty), 32'(pending.size() == 0));
      checkOutput("full", 32'(full), 32'(pending.size() == 16));
      checkOutput("overflow", 32'(overflow), 32'(m_overflow));
      checkOutput("rd_addr", 32'(rd_addr), 32'(m_fetches % 16));
      if (!m_corrupt) checkOutput("out_data", out_data, m_data);
    end
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b1;
    wen       = 1'b0;
    out_ready = 1'b0;
    wdata     = 32'h0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    modelReset();

    doReset();

    $display("[TB] single write latency");
    applyStimulus(1'b1, 1'b0, 32'hA5A5A5A5);
    checkOutput("lat_count_after_wen", 32'(count), 32'd1);
    checkOutput("lat_valid_after_wen", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("lat_valid_2edges", 32'(out_valid), 32'd1);
    checkOutput("lat_data", out_data, 32'hA5A5A5A5);
    checkOutput("lat_count_after_pop", 32'(count), 32'd0);
    checkOutput("lat_rd_addr", 32'(rd_addr), 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0);

    $display("[TB] streaming 20 writes");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, 32'(i % 16));
      checkOutput("stream_count_le1", 32'(count <= 5'd1), 32'd1);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("stream_last_data", out_data, 32'd3);
    checkOutput("stream_rd_addr", 32'(rd_addr), 32'd5);
    checkOutput("stream_overflow", 32'(overflow), 32'd0);

    $display("[TB] fill to full and overflow");
    doReset();
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b0, 32'h200 + 32'(i));
    checkOutput("fill_count", 32'(count), 32'd16);
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_held_data", out_data, 32'h200);
    applyStimulus(1'b1, 1'b1, 32'h211);
    checkOutput("full_pushpop_count", 32'(count), 32'd16);
    checkOutput("full_pushpop_overflow", 32'(overflow), 32'd0);
    checkOutput("full_pushpop_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h212);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_count", 32'(count), 32'd16);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);

    $display("[TB] backpressure toggling");
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 32'h300 + 32'(i));
    checkOutput("bp_count", 32'(count), 32'd7);
    delivered.delete();
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'(i % 2), 32'h0);
    checkOutput("bp_delivered_n", 32'(delivered.size()), 32'd8);
    for (int k = 0; k < delivered.size(); k++)
      checkOutput("bp_delivered_val", delivered[k], 32'h300 + 32'(k));

    $display("[TB] reset while holding");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'h400 + 32'(i));
    checkOutput("hold_count", 32'(count), 32'd5);
    checkOutput("hold_valid", 32'(out_valid), 32'd1);
    doReset();
    applyStimulus(1'b1, 1'b0, 32'hBEEF0001);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("post_rst_valid", 32'(out_valid), 32'd1);
    checkOutput("post_rst_data", out_data, 32'hBEEF0001);
    checkOutput("post_rst_rd_addr", 32'(rd_addr), 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_buffer_reader.md
# spike_buffer_reader

Read-side controller for the 16-entry spike packet buffer whose write address is produced by the `wen`-driven 4-bit write counter, which resets to 4'b1111 so that the first write lands in entry 0. The block mirrors the write traffic to track occupancy, fetches entries in write order through a combinational read port, and presents them on a registered valid/ready output stage to the downstream router/neuron logic. It also flags empty, full and overflow.

## Interface
- `DATA_WIDTH`, 32: packet width of a buffer entry.
- `DEPTH`, 16: number of buffer entries. Fixed by the 4-bit write counter; must be a power of two.
- `clk` input 1: clock. All state in this block updates on the rising edge.
- `reset_n` input 1: one clock; reset is asynchronous and active-low.
- `wen` input 1: the write enable that also drives the buffer's write counter. One entry is written per cycle it is high.
- `rd_addr` output 4: read address to the buffer's combinational read port; equals `rd_ptr`.
- `rd_data` input DATA_WIDTH: buffer contents at `rd_addr`, valid in the same cycle.
- `out_valid` output 1: output register holds a packet.
- `out_ready` input 1: consumer accepts the packet this cycle.
- `out_data` output DATA_WIDTH: packet presented to the consumer.
- `count` output 5: entries written but not yet fetched, 0..16. Excludes the output register.
- `empty` output 1: `count == 0`.
- `full` output 1: `count == 16`.
- `overflow` output 1: sticky error flag.

## Operation
- Reset values:
  - `rd_ptr` = 0; `count` = 0; `empty` = 1; `full` = 0; `overflow` = 0.
  - `out_valid` = 0; `out_data` = 0; FSM in IDLE.
- Entry visibility: an entry written with `wen` sampled high at edge N is readable from edge N+1 onward. The writer commits it on the preceding falling edge.
- `push` = `wen` and not dropped. A write is dropped only when `count == 16` and there is no `pop` in the same cycle.
- `pop` = a fetch from the buffer into the output register, which occurs when:
  - the FSM is in IDLE and `count > 0`, or
  - the FSM is in HOLD, `out_ready` = 1 and `count > 0`.
- On `pop`: `out_data` <= `rd_data`, and `rd_ptr` <= `rd_ptr + 1` (mod 16, wraps 15 -> 0).
- Count update: `count` <= `count + push - pop`. Simultaneous push and pop leaves `count` unchanged, including when full and when `count == 1`.
- FSM states:
  - IDLE: `out_valid` = 0. If `count > 0`, pop and go to HOLD; otherwise stay.
  - HOLD: `out_valid` = 1.
    - With `out_ready` = 0: stay; `out_data` and `rd_ptr` are stable.
    - With `out_ready` = 1 and `count > 0`: pop (back-to-back) and stay in HOLD.
    - With `out_ready` = 1 and `count == 0`: go to IDLE.
- Overflow: a `wen` arriving while `count == 16` with no same-cycle pop sets `overflow`.
  - The write counter has already overwritten the oldest unfetched entry, so the data is corrupt.
  - `count` stays at 16. `overflow` clears only on reset.
- `empty` and `full` are combinational decodes of registered `count`.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). A packet held in the output register is discarded. The writer's counter is reset by the same `reset_n`, so both pointers realign.

## Timing
- Write-to-output latency: `wen` at edge N, with the block IDLE and `count == 0` before N:
  - `count` = 1 after N;
  - pop at N+1, so `out_valid` = 1 and `out_data` = the entry after N+1. That is 2 rising edges.
- Throughput: 1 packet per cycle while `out_ready` = 1 and `count > 0`.
- Handshake: a transfer occurs on a rising edge where `out_valid` and `out_ready` are both 1. While `out_valid` = 1 and `out_ready` = 0, `out_data` must not change.
- `out_ready` may be asserted at any time; it has no effect in IDLE.
- There are no combinational paths from `out_ready` or `wen` to any output. `rd_addr` is driven from a register.

## Test plan
- Reset, then single `wen`, with entry 0 holding 0xA5A5A5A5 -> `count` goes 0->1->0. `out_valid` rises 2 edges after `wen` with `out_data` = 0xA5A5A5A5. `rd_addr` = 1 afterward.
- 20 consecutive `wen` with `out_ready` = 1 and entries holding 0..15 -> outputs appear in order 0,1,...,15,0,... with no gaps after the first. `count` never exceeds 1. `rd_addr` wraps 15->0. `overflow` = 0.
- `out_ready` = 0 while 17 writes are issued -> one packet held stable in the output register; `count` = 16 and `full` = 1 after 17 writes (the first is already fetched). An 18th `wen` sets `overflow` = 1 and `count` stays 16.
- At `count` = 16, `out_ready` = 1 and `wen` = 1 in the same cycle -> transfer occurs, `count` stays 16, `overflow` = 0.
- Backpressure toggling `out_ready` every other cycle over 8 buffered entries -> each packet is delivered exactly once, in order, with no change of `out_data` while stalled.
- Assert `reset_n` low while in HOLD with `count` = 5 -> immediately `out_valid` = 0, `count` = 0, `empty` = 1, `rd_addr` = 0, `overflow` = 0. After release, the next `wen` is delivered from entry 0.
